// File: rtl/zap_decode_mem_pkg.sv
// Shared field positions, ARM opcode constants and FSM encoding for the
// LDM/STM splitter in the decode front end.
package zap_decode_mem_pkg;

  localparam int INS_W = 35;
  localparam int B_P   = 24;
  localparam int B_U   = 23;
  localparam int B_S   = 22;
  localparam int B_W   = 21;
  localparam int B_L   = 20;

  localparam logic [2:0] CLS_BLOCK    = 3'b100;
  localparam logic [2:0] CLS_LDST_IMM = 3'b010;
  localparam logic [2:0] CLS_DP_IMM   = 3'b001;
  localparam logic [3:0] OP_ADD       = 4'b0100;
  localparam logic [3:0] OP_SUB       = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2
  } state_e;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/zap_decode_mem_offset.sv
// Per-micro-op address math: register count, next register index and the
// signed immediate for that register relative to the base.
module zap_decode_mem_offset
  import zap_decode_mem_pkg::*;
(
  input  logic        p_i,
  input  logic        u_i,
  input  logic        comp_i,
  input  logic [15:0] list_i,
  input  logic [15:0] sel_i,
  output logic [4:0]  n_o,
  output logic [3:0]  idx_o,
  output logic        up_o,
  output logic [11:0] imm12_o
);

  logic [4:0]        k;
  logic signed [9:0] n4, k4, base, off;
  logic [9:0]        mag;

  // sel_i holds the current register and everything above it, so its
  // popcount tells how many registers were already issued.
  assign n_o = popcnt16(list_i);
  assign k   = n_o - popcnt16(sel_i);
  assign n4  = signed'({3'b000, n_o, 2'b00});
  assign k4  = signed'({3'b000, k, 2'b00});

  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) if (sel_i[i]) idx_o = 4'(i);
  end

  always_comb begin
    case ({p_i, u_i})
      2'b01:   base = 10'sd0;
      2'b11:   base = 10'sd4;
      2'b00:   base = 10'sd4 - n4;
      default: base = -n4;
    endcase
    off = base + k4;
    // PC load issued after writeback must undo the base update.
    if (comp_i) off = u_i ? (off - n4) : (off + n4);
  end

  assign up_o    = ~off[9];
  assign mag     = off[9] ? 10'(-off) : 10'(off);
  assign imm12_o = {2'b00, mag};

endmodule

// File: rtl/zap_decode_mem_fsm.sv
// Splits LDM/STM into single LDR/STR micro-ops plus optional base writeback,
// freezing fetch while the sequence runs; everything else passes through.
module zap_decode_mem_fsm
  import zap_decode_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fiq,
  input  logic        i_irq,
  input  logic [31:0] i_cpsr_ff,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_stall_from_decode,
  output logic        o_fiq,
  output logic        o_irq
);

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;

  logic [15:0] lst, sel, rest;
  logic [3:0]  rn, idx;
  logic [4:0]  n;
  logic [11:0] imm12;
  logic        blk, wb_en, pc_case, comp, up, emit_wb, active;
  logic [34:0] ld_op, wb_op;
  logic        unused_cpsr;

  assign unused_cpsr = ^i_cpsr_ff;

  assign lst     = i_instruction[15:0];
  assign rn      = i_instruction[19:16];
  assign blk     = i_instruction_valid && (i_instruction[27:25] == CLS_BLOCK) &&
                   !i_instruction[B_S] && (lst != 16'd0);
  assign wb_en   = i_instruction[B_W] && !(i_instruction[B_L] && lst[rn]);
  assign pc_case = i_instruction[B_L] && lst[15] && wb_en;
  assign sel     = (state_q == S_IDLE) ? lst : mask_q;
  assign rest    = sel & ~(sel & (~sel + 16'd1));
  assign comp    = pc_case && (idx == 4'd15);
  assign active  = (state_q != S_IDLE) || blk;
  // A lone PC load with writeback starts with the writeback itself.
  assign emit_wb = (state_q == S_WB) || ((state_q == S_IDLE) && pc_case && (lst == 16'h8000));

  zap_decode_mem_offset u_off (
    .p_i     (i_instruction[B_P]),
    .u_i     (i_instruction[B_U]),
    .comp_i  (comp),
    .list_i  (lst),
    .sel_i   (sel),
    .n_o     (n),
    .idx_o   (idx),
    .up_o    (up),
    .imm12_o (imm12)
  );

  assign ld_op = {i_instruction[34:28], CLS_LDST_IMM, 1'b1, up, 1'b0, 1'b0,
                  i_instruction[B_L], rn, idx, imm12};
  assign wb_op = {i_instruction[34:28], CLS_DP_IMM,
                  i_instruction[B_U] ? OP_ADD : OP_SUB, 1'b0, rn, rn, 4'h0,
                  {1'b0, n, 2'b00}};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mask_q  <= 16'd0;
    end else if (i_clear_from_writeback || i_clear_from_alu) begin
      state_q <= S_IDLE;
      mask_q  <= 16'd0;
    end else if (!(i_data_stall || i_stall_from_shifter || i_stall_from_issue)) begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    mask_d  = 16'd0;
    case (state_q)
      S_IDLE, S_XFER: begin
        if (state_q == S_IDLE && !blk) begin
          state_d = S_IDLE;
        end else if (emit_wb) begin
          state_d = S_XFER;
          mask_d  = lst;
        end else if (rest != 16'd0) begin
          state_d = (pc_case && rest == 16'h8000) ? S_WB : S_XFER;
          mask_d  = rest;
        end else if (wb_en && !pc_case) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (mask_q != 16'd0) begin
          state_d = S_XFER;
          mask_d  = mask_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_instruction       = i_instruction;
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = 1'b0;
    o_irq               = i_irq;
    o_fiq               = i_fiq;
    if (active) begin
      o_instruction       = emit_wb ? wb_op : ld_op;
      o_instruction_valid = 1'b1;
      o_stall_from_decode = (state_d != S_IDLE);
      o_irq               = 1'b0;
      o_fiq               = 1'b0;
    end
  end

endmodule
